// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control slice: FSM encodings,
// default prescaler divisor and the decoded button-event bundle.
package stopwatch_pkg;

    localparam int unsigned CLK_DIV_DEFAULT = 1000000;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    typedef struct packed {
        logic lap;
        logic clear;
        logic start_stop;
    } btn_evt_t;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button / counter-chain / display signals of the stopwatch controller.
// The slave modport is the controller side, master is its environment.
interface stopwatch_ctrl_if;

    logic       start_stop_btn;
    logic       clear_btn;
    logic       lap_btn;
    logic       mode_down;
    logic       chain_at_limit;
    logic       cnt_enable;
    logic       cnt_up_down;
    logic       cnt_clear;
    logic       disp_hold;
    logic       done;
    logic [1:0] state;

    modport master (
        output start_stop_btn, clear_btn, lap_btn, mode_down, chain_at_limit,
        input  cnt_enable, cnt_up_down, cnt_clear, disp_hold, done, state
    );

    modport slave (
        input  start_stop_btn, clear_btn, lap_btn, mode_down, chain_at_limit,
        output cnt_enable, cnt_up_down, cnt_clear, disp_hold, done, state
    );

endinterface

// File: rtl/button_sync.sv
// Two-flop synchronizer plus rising-edge detect for one raw button.
// Emits a registered one-cycle press pulse on the 3rd clk edge after the raw rise.
module button_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic [1:0] sync_reg;
    logic       prev_reg;
    logic [1:0] vld_reg;
    logic       armed_reg;
    logic       press_reg;

    // armed_reg stays low until the synchronized level has been seen released,
    // so a button held through reset does not produce a press on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg  <= '0;
            prev_reg  <= 1'b0;
            vld_reg   <= '0;
            armed_reg <= 1'b0;
            press_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], btn};
            prev_reg  <= sync_reg[1];
            vld_reg   <= {vld_reg[0], 1'b1};
            armed_reg <= armed_reg | (vld_reg[1] & ~sync_reg[1]);
            press_reg <= sync_reg[1] & ~prev_reg & armed_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, run/pause/done FSM, step prescaler,
// direction latch and lap hold driving an external digit-counter chain.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    stopwatch_ctrl_if.slave bus
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [2:0] btn_raw;
    logic [2:0] btn_press;
    btn_evt_t   evt;

    assign btn_raw = {bus.lap_btn, bus.clear_btn, bus.start_stop_btn};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            button_sync u_sync (
                .clk   (clk),
                .rst   (rst),
                .btn   (btn_raw[gi]),
                .press (btn_press[gi])
            );
        end
    endgenerate

    assign evt = btn_press;

    logic [1:0]    state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic          mode_reg, mode_next;
    logic          mode_chg_reg;
    logic          cnt_enable_reg, enable_next;
    logic          cnt_clear_reg, clear_next;
    logic          cnt_up_down_reg;
    logic          disp_hold_reg, hold_next;
    logic          done_reg;
    logic          tick;

    always_comb begin
        state_next  = state_reg;
        enable_next = 1'b0;
        clear_next  = mode_chg_reg;
        hold_next   = disp_hold_reg;
        tick        = (state_reg == ST_RUN) && (presc_reg == PRESC_LAST);
        mode_next   = (state_reg == ST_IDLE) ? bus.mode_down : mode_reg;

        if (evt.clear) begin
            state_next = ST_IDLE;
            clear_next = 1'b1;
            hold_next  = 1'b0;
        end else if (evt.start_stop) begin
            case (state_reg)
                ST_IDLE, ST_PAUSE: state_next = ST_RUN;
                ST_RUN:            state_next = ST_PAUSE;
                default:           state_next = state_reg;
            endcase
        end else begin
            // A countdown stops at all-zeros instead of wrapping to all-nines.
            if (tick) begin
                if (mode_reg && bus.chain_at_limit)
                    state_next = ST_DONE;
                else
                    enable_next = 1'b1;
            end
            // Lap only yields to events that change state in the same cycle.
            if (evt.lap && (state_reg == ST_RUN || state_reg == ST_PAUSE))
                hold_next = ~disp_hold_reg;
        end

        if (clear_next)
            enable_next = 1'b0;

        presc_next = '0;
        if (state_reg == ST_RUN && state_next == ST_RUN && !tick)
            presc_next = presc_reg + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            presc_reg       <= '0;
            mode_reg        <= 1'b0;
            mode_chg_reg    <= 1'b0;
            cnt_enable_reg  <= 1'b0;
            cnt_clear_reg   <= 1'b0;
            cnt_up_down_reg <= 1'b1;
            disp_hold_reg   <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            presc_reg       <= presc_next;
            mode_reg        <= mode_next;
            mode_chg_reg    <= (mode_next != mode_reg);
            cnt_enable_reg  <= enable_next;
            cnt_clear_reg   <= clear_next;
            cnt_up_down_reg <= ~mode_next;
            disp_hold_reg   <= hold_next;
            done_reg        <= (state_next == ST_DONE);
        end
    end

    assign bus.state       = state_reg;
    assign bus.cnt_enable  = cnt_enable_reg;
    assign bus.cnt_clear   = cnt_clear_reg;
    assign bus.cnt_up_down = cnt_up_down_reg;
    assign bus.disp_hold   = disp_hold_reg;
    assign bus.done        = done_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (CLK_DIV=4): directed scenarios then random buttons,
// every cycle compared against an event-level reference model.
module tb_stopwatch_ctrl;

    localparam int DIV = 4;
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn = '0;      // [0] start_stop, [1] clear, [2] lap
    logic       mode_down = 1'b0;
    logic       chain = 1'b0;
    int         vectors = 0;
    int         miscompares = 0;
    int         hold_left [3];

    stopwatch_ctrl_if sw_if ();

    assign sw_if.start_stop_btn = btn[0];
    assign sw_if.clear_btn      = btn[1];
    assign sw_if.lap_btn        = btn[2];
    assign sw_if.mode_down      = mode_down;
    assign sw_if.chain_at_limit = chain;

    stopwatch_ctrl #(.CLK_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw_if)
    );

    always #5 clk = ~clk;

    // Reference model: a press is acted on 3 edges after its raw level was first
    // sampled high (two sync stages plus the edge-detect register).
    logic [3:0] m_hist [3];
    logic [3:0] n_hist [3];
    logic [2:0] press;
    logic [1:0] m_state, n_state;
    int         m_age, n_age;
    logic       m_mode, n_mode, m_chg, n_chg, tick;
    logic       exp_en, exp_clr, exp_hold, exp_up, exp_done;
    logic       n_en, n_clr, n_hold;

    always_comb begin
        for (int b = 0; b < 3; b++) begin
            n_hist[b] = {m_hist[b][2:0], btn[b]};
            press[b]  = m_hist[b][2] & ~m_hist[b][3];
        end
        n_state = m_state;
        n_age   = m_age;
        n_en    = 1'b0;
        n_clr   = m_chg;
        n_hold  = exp_hold;
        n_mode  = (m_state == S_IDLE) ? mode_down : m_mode;
        n_chg   = (n_mode != m_mode);
        tick    = (m_state == S_RUN) && (((m_age + 1) % DIV) == 0);
        if (m_state == S_RUN) n_age = m_age + 1;
        if (press[1]) begin
            n_state = S_IDLE;
            n_clr   = 1'b1;
            n_hold  = 1'b0;
        end else if (press[0]) begin
            if (m_state == S_IDLE || m_state == S_PAUSE) begin
                n_state = S_RUN;
                n_age   = 0;
            end else if (m_state == S_RUN) begin
                n_state = S_PAUSE;
            end
        end else begin
            if (tick) begin
                if (m_mode && chain) n_state = S_DONE;
                else                 n_en = 1'b1;
            end
            if (press[2] && (m_state == S_RUN || m_state == S_PAUSE)) n_hold = ~exp_hold;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 3; b++) m_hist[b] <= {4{btn[b]}};
            m_state  <= S_IDLE;
            m_age    <= 0;
            m_mode   <= 1'b0;
            m_chg    <= 1'b0;
            exp_en   <= 1'b0;
            exp_clr  <= 1'b0;
            exp_hold <= 1'b0;
            exp_up   <= 1'b1;
            exp_done <= 1'b0;
        end else begin
            for (int b = 0; b < 3; b++) m_hist[b] <= n_hist[b];
            m_state  <= n_state;
            m_age    <= n_age;
            m_mode   <= n_mode;
            m_chg    <= n_chg;
            exp_en   <= n_en;
            exp_clr  <= n_clr;
            exp_hold <= n_hold;
            exp_up   <= ~n_mode;
            exp_done <= (n_state == S_DONE);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("state", 32'(sw_if.state), 32'(m_state));
        chk("cnt_enable", 32'(sw_if.cnt_enable), 32'(exp_en));
        chk("cnt_clear", 32'(sw_if.cnt_clear), 32'(exp_clr));
        chk("cnt_up_down", 32'(sw_if.cnt_up_down), 32'(exp_up));
        chk("disp_hold", 32'(sw_if.disp_hold), 32'(exp_hold));
        chk("done", 32'(sw_if.done), 32'(exp_done));
        chk("en_clr_exclusive", 32'(sw_if.cnt_enable & sw_if.cnt_clear), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, 32'(sw_if.state), 32'(S_IDLE));
        chk({tag, "_en"}, 32'(sw_if.cnt_enable), 32'd0);
        chk({tag, "_clr"}, 32'(sw_if.cnt_clear), 32'd0);
        chk({tag, "_up"}, 32'(sw_if.cnt_up_down), 32'd1);
        chk({tag, "_hold"}, 32'(sw_if.disp_hold), 32'd0);
        chk({tag, "_done"}, 32'(sw_if.done), 32'd0);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_model();
        end
    endtask

    task automatic press_btn(input int idx, input int cycles);
        btn[idx] = 1'b1;
        step(cycles);
        btn[idx] = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s, input int bound);
        int k = 0;
        while (sw_if.state !== s && k < bound) begin
            step(1);
            k++;
        end
        chk(tag, 32'(sw_if.state), 32'(s));
    endtask

    initial begin
        int clr_cnt;
        int saw_pause;

        // Reset state
        step(3);
        chk_reset("reset");
        rst = 1'b0;
        step(6);

        // Free-running up count: enable every DIV cycles from RUN entry
        press_btn(0, 2);
        wait_state("enter_run", S_RUN, 10);
        for (int i = 1; i <= 20; i++) begin
            step(1);
            chk($sformatf("run_en_c%0d", i), 32'(sw_if.cnt_enable), 32'((i % DIV) == 0));
        end

        // Pause holds off enables; resume restarts the full period
        press_btn(0, 2);
        wait_state("enter_pause", S_PAUSE, 10);
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("pause_no_en", 32'(sw_if.cnt_enable), 32'd0);
        end
        press_btn(0, 2);
        wait_state("resume_run", S_RUN, 10);
        for (int i = 1; i <= DIV; i++) begin
            step(1);
            chk($sformatf("resume_en_c%0d", i), 32'(sw_if.cnt_enable), 32'(i == DIV));
        end
        press_btn(1, 2);
        wait_state("clear_to_idle", S_IDLE, 10);
        step(2);

        // Countdown: mode latch issues one clear, then DONE at first tick at limit
        mode_down = 1'b1;
        clr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (sw_if.cnt_clear === 1'b1) clr_cnt++;
        end
        chk("mode_clear_count", 32'(clr_cnt), 32'd1);
        chk("mode_up_down", 32'(sw_if.cnt_up_down), 32'd0);
        chain = 1'b1;
        press_btn(0, 2);
        wait_state("down_run", S_RUN, 10);
        wait_state("down_done", S_DONE, 12);
        chk("done_flag", 32'(sw_if.done), 32'd1);
        press_btn(2, 2);
        step(5);
        chk("lap_in_done", 32'(sw_if.disp_hold), 32'd0);
        press_btn(0, 2);
        step(5);
        chk("start_in_done", 32'(sw_if.state), 32'(S_DONE));
        press_btn(1, 2);
        wait_state("done_clear", S_IDLE, 10);
        mode_down = 1'b0;
        chain = 1'b0;
        step(4);

        // Simultaneous clear and start during RUN
        press_btn(0, 2);
        wait_state("sim_run", S_RUN, 10);
        step(3);
        btn[0] = 1'b1;
        btn[1] = 1'b1;
        clr_cnt = 0;
        saw_pause = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (i == 1) btn = '0;
            if (sw_if.cnt_clear === 1'b1) clr_cnt++;
            if (sw_if.state === S_PAUSE) saw_pause = 1;
        end
        chk("sim_clear_count", 32'(clr_cnt), 32'd1);
        chk("sim_no_pause", 32'(saw_pause), 32'd0);
        chk("sim_idle", 32'(sw_if.state), 32'(S_IDLE));

        // Lap toggling and clear releasing the hold
        press_btn(0, 2);
        wait_state("lap_run", S_RUN, 10);
        press_btn(2, 2);
        step(4);
        chk("lap1", 32'(sw_if.disp_hold), 32'd1);
        press_btn(2, 2);
        step(4);
        chk("lap2", 32'(sw_if.disp_hold), 32'd0);
        press_btn(2, 2);
        step(4);
        chk("lap3", 32'(sw_if.disp_hold), 32'd1);
        press_btn(1, 2);
        step(4);
        chk("lap_clear", 32'(sw_if.disp_hold), 32'd0);

        // mode_down ignored in RUN; reset mid-RUN is immediate
        press_btn(0, 2);
        wait_state("rst_run", S_RUN, 10);
        mode_down = 1'b1;
        step(4);
        chk("mode_ignored_run", 32'(sw_if.cnt_up_down), 32'd1);
        mode_down = 1'b0;
        step(1);
        rst = 1'b1;
        #1;
        chk_reset("mid_rst");
        btn[0] = 1'b1;
        step(2);
        rst = 1'b0;
        step(8);
        chk("held_through_rst", 32'(sw_if.state), 32'(S_IDLE));
        btn[0] = 1'b0;
        step(3);
        press_btn(0, 2);
        wait_state("fresh_press", S_RUN, 10);

        // Random buttons, direction and limit flag
        for (int b = 0; b < 3; b++) hold_left[b] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold_left[b] > 0) begin
                    btn[b] = 1'b1;
                    hold_left[b]--;
                end else begin
                    btn[b] = 1'b0;
                    if ($urandom_range(0, (b == 1) ? 39 : 9) == 0)
                        hold_left[b] = int'($urandom_range(1, 5));
                end
            end
            if ($urandom_range(0, 19) == 0) mode_down = ~mode_down;
            chain = ($urandom_range(0, 2) == 0);
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 1000000, clk cycles per counter step (100 Hz at 100 MHz); legal range 2..2^24.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start_stop_btn  in  1  raw asynchronous button, level-high when pressed.
REQ-005 clear_btn  in  1  raw asynchronous button.
REQ-006 lap_btn  in  1  raw asynchronous button.
REQ-007 mode_down  in  1  requested direction, 1 = countdown.
REQ-008 chain_at_limit  in  1  AND of all digit-counter threshold outputs.
REQ-009 cnt_enable  out  1  one-cycle step pulse to the digit-counter chain.
REQ-010 cnt_up_down  out  1  direction to the counters, 1 = up.
REQ-011 cnt_clear  out  1  one-cycle clear pulse to the counters' reset inputs.
REQ-012 disp_hold  out  1  lap freeze for the display path.
REQ-013 done  out  1  countdown reached zero.
REQ-014 state  out  2  current FSM state encoding.

Function
REQ-015 Each button SHALL pass a 2-flop synchronizer, then rising-edge detect; press pulse is 1 cycle, asserted on the 3rd clk edge after the raw rise; held buttons give one pulse.
REQ-016 FSM states: IDLE=00, RUN=01, PAUSE=10, DONE=11; state output equals encoding.
REQ-017 Event priority within a cycle: clear > start_stop > tick > lap.
REQ-018 Prescaler SHALL count 0..CLK_DIV-1 only in RUN; held at 0 in all other states; tick when count = CLK_DIV-1, then wraps to 0.
REQ-019 First cnt_enable SHALL occur exactly CLK_DIV cycles after the cycle state becomes RUN; resuming from PAUSE restarts the full period.
REQ-020 IDLE: start -> RUN; clear -> cnt_clear pulse, remain IDLE.
REQ-021 RUN: tick -> cnt_enable=1 for that cycle; start -> PAUSE; clear -> IDLE plus cnt_clear.
REQ-022 RUN with latched mode down: tick while chain_at_limit=1 -> DONE, cnt_enable SHALL NOT assert (no wrap to all-nines).
REQ-023 Up mode never enters DONE; the chain wraps freely.
REQ-024 PAUSE: start -> RUN; clear -> IDLE plus cnt_clear; cnt_enable=0.
REQ-025 DONE: done=1, cnt_enable=0; start and lap ignored; clear -> IDLE plus cnt_clear.
REQ-026 mode_down SHALL be latched into a mode register only in IDLE; ignored in RUN/PAUSE/DONE; cnt_up_down = NOT mode register.
REQ-027 A change of the latched mode in IDLE SHALL issue one cnt_clear pulse the following cycle, so the counters reload their direction-dependent reset value.
REQ-028 Lap pulse in RUN or PAUSE toggles disp_hold; ignored in IDLE/DONE; any clear forces disp_hold=0.
REQ-029 All outputs SHALL be registered; cnt_clear and cnt_enable never assert in the same cycle.

Reset
REQ-030 During and after rst: state=IDLE, prescaler=0, synchronizers=0, mode register=0, cnt_up_down=1, cnt_enable=0, cnt_clear=0, disp_hold=0, done=0.
REQ-031 rst asserted mid-operation SHALL abort immediately with no cnt_enable or cnt_clear pulse on release; the first press after release requires a fresh rising edge.

Structure
REQ-032 Package stopwatch_pkg SHALL hold the state encodings and the default CLK_DIV.
REQ-033 Sub-module button_sync (synchronizer plus edge detect) SHALL be instantiated three times; FSM, prescaler and mode latch stay in stopwatch_ctrl.

Verification (CLK_DIV=4)
REQ-034 Reset, start press, run 20 cycles -> RUN, cnt_enable at cycles 4, 8, 12, 16, 20 after RUN entry, no others.
REQ-035 Start, start after 6 cycles, start again -> PAUSE with no enable; first enable 4 cycles after re-entering RUN.
REQ-036 mode_down=1 in IDLE -> cnt_up_down=0, one cnt_clear; start with chain_at_limit=1 -> DONE at first tick, no cnt_enable, done=1.
REQ-037 Clear and start pulses in the same cycle during RUN -> IDLE, one cnt_clear, no PAUSE.
REQ-038 Lap twice in RUN -> disp_hold 1 then 0; lap in DONE has no effect; clear with disp_hold=1 -> 0.
REQ-039 Toggle mode_down in RUN -> no cnt_up_down change; rst mid-RUN -> all outputs at reset values within the same cycle.
